// File: rtl/i2c_controller_if.sv
// rtl/i2c_controller_if.sv - command/response handshake and open-drain bus signals of i2c_controller
interface i2c_controller_if;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [1:0] cmd_op;
  logic [7:0] cmd_data;
  logic       cmd_nack_last;
  logic       rsp_valid;
  logic [7:0] rsp_data;
  logic       rsp_nack;
  logic       busy;
  logic       scl_in;
  logic       sda_in;
  logic       scl_oe;
  logic       sda_oe;

  modport slave (
    input  cmd_valid, cmd_op, cmd_data, cmd_nack_last, scl_in, sda_in,
    output cmd_ready, rsp_valid, rsp_data, rsp_nack, busy, scl_oe, sda_oe
  );

  modport master (
    output cmd_valid, cmd_op, cmd_data, cmd_nack_last, scl_in, sda_in,
    input  cmd_ready, rsp_valid, rsp_data, rsp_nack, busy, scl_oe, sda_oe
  );
endinterface

// File: rtl/i2c_controller.sv
// rtl/i2c_controller.sv - byte-level I2C bus initiator: START/rSTART/STOP/WRITE/READ with clock stretching
module i2c_controller #(
  parameter int CLK_DIV = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  i2c_controller_if.slave   bus
);
  typedef enum logic [2:0] {IDLE, START, WRBIT, RDBIT, ACK, STOP} state_t;

  localparam logic [8:0] QTR    = 9'(CLK_DIV - 1);
  localparam logic [8:0] SETTLE = 9'(CLK_DIV + 1);
  localparam logic [8:0] HALF   = 9'(2 * CLK_DIV - 1);

  state_t     state;
  logic [1:0] phase;
  logic [8:0] cnt;
  logic [2:0] bit_cnt;
  logic [7:0] shreg;
  logic       op_rd;
  logic       nack_last;
  logic       ack_smp;
  logic [1:0] scl_sync;
  logic [1:0] sda_sync;
  logic       scl_hi;
  logic       sda_hi;

  assign scl_hi = scl_sync[1];
  assign sda_hi = sda_sync[1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scl_sync <= 2'b11;
      sda_sync <= 2'b11;
    end else begin
      scl_sync <= {scl_sync[0], bus.scl_in};
      sda_sync <= {sda_sync[0], bus.sda_in};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      phase         <= 2'd0;
      cnt           <= '0;
      bit_cnt       <= '0;
      shreg         <= '0;
      op_rd         <= 1'b0;
      nack_last     <= 1'b0;
      ack_smp       <= 1'b0;
      bus.cmd_ready <= 1'b1;
      bus.rsp_valid <= 1'b0;
      bus.rsp_data  <= '0;
      bus.rsp_nack  <= 1'b0;
      bus.busy      <= 1'b0;
      bus.scl_oe    <= 1'b0;
      bus.sda_oe    <= 1'b0;
    end else begin
      bus.rsp_valid <= 1'b0;
      case (state)
        IDLE: if (bus.cmd_valid && bus.cmd_ready) begin
          cnt       <= '0;
          bit_cnt   <= '0;
          shreg     <= bus.cmd_data;
          op_rd     <= (bus.cmd_op == 2'd2);
          nack_last <= bus.cmd_nack_last;
          case (bus.cmd_op)
            2'd0: begin
              state         <= START;
              bus.cmd_ready <= 1'b0;
              bus.sda_oe    <= 1'b0;
              if (bus.busy) phase <= 2'd0;
              else begin
                phase      <= 2'd1;
                bus.scl_oe <= 1'b0;
              end
            end
            2'd1, 2'd2: if (bus.busy) begin
              state         <= (bus.cmd_op == 2'd1) ? WRBIT : RDBIT;
              phase         <= 2'd0;
              bus.cmd_ready <= 1'b0;
              bus.sda_oe    <= (bus.cmd_op == 2'd1) ? ~bus.cmd_data[7] : 1'b0;
            end else begin
              bus.rsp_valid <= 1'b1;
              bus.rsp_nack  <= 1'b1;
            end
            default: if (bus.busy) begin
              state         <= STOP;
              phase         <= 2'd0;
              bus.cmd_ready <= 1'b0;
              bus.sda_oe    <= 1'b1;
            end else begin
              bus.rsp_valid <= 1'b1;
              bus.rsp_nack  <= 1'b0;
            end
          endcase
        end
        WRBIT, RDBIT, ACK: case (phase)
          2'd0, 2'd1: if (cnt == QTR) begin
            cnt   <= '0;
            phase <= phase + 2'd1;
            if (phase == 2'd1) bus.scl_oe <= 1'b0;
          end else cnt <= cnt + 9'd1;
          // A target stretching SCL simply freezes the count here.
          2'd2: if (scl_hi) begin
            if (cnt == QTR) begin
              cnt   <= '0;
              phase <= 2'd3;
            end else cnt <= cnt + 9'd1;
          end
          default: begin
            if (cnt == '0) begin
              if (state == RDBIT) shreg <= {shreg[6:0], sda_hi};
              ack_smp <= sda_hi;
            end
            if (cnt == QTR) begin
              cnt        <= '0;
              phase      <= 2'd0;
              bus.scl_oe <= 1'b1;
              case (state)
                WRBIT: begin
                  shreg <= {shreg[6:0], 1'b0};
                  if (bit_cnt == 3'd7) begin
                    state      <= ACK;
                    bus.sda_oe <= 1'b0;
                  end else begin
                    bit_cnt    <= bit_cnt + 3'd1;
                    bus.sda_oe <= ~shreg[6];
                  end
                end
                RDBIT: if (bit_cnt == 3'd7) begin
                  state      <= ACK;
                  bus.sda_oe <= ~nack_last;
                end else bit_cnt <= bit_cnt + 3'd1;
                default: begin
                  state         <= IDLE;
                  bus.cmd_ready <= 1'b1;
                  bus.rsp_valid <= 1'b1;
                  bus.rsp_nack  <= op_rd ? nack_last : ack_smp;
                  if (op_rd) bus.rsp_data <= shreg;
                end
              endcase
            end else cnt <= cnt + 9'd1;
          end
        endcase
        START: case (phase)
          2'd0: if (cnt == QTR) begin
            cnt        <= '0;
            phase      <= 2'd1;
            bus.scl_oe <= 1'b0;
          end else cnt <= cnt + 9'd1;
          // First two cycles cover synchronizer latency whether SCL was high or just released.
          2'd1: if (cnt < 9'd2 || scl_hi) begin
            if (cnt == SETTLE) begin
              cnt        <= '0;
              phase      <= 2'd2;
              bus.sda_oe <= 1'b1;
            end else cnt <= cnt + 9'd1;
          end
          2'd2: if (cnt == HALF) begin
            cnt        <= '0;
            phase      <= 2'd3;
            bus.scl_oe <= 1'b1;
          end else cnt <= cnt + 9'd1;
          default: if (cnt == QTR) begin
            cnt           <= '0;
            state         <= IDLE;
            bus.cmd_ready <= 1'b1;
            bus.rsp_valid <= 1'b1;
            bus.rsp_nack  <= 1'b0;
            bus.busy      <= 1'b1;
          end else cnt <= cnt + 9'd1;
        endcase
        STOP: case (phase)
          2'd0: if (cnt == QTR) begin
            cnt        <= '0;
            phase      <= 2'd1;
            bus.scl_oe <= 1'b0;
          end else cnt <= cnt + 9'd1;
          2'd1: if (scl_hi) begin
            if (cnt == QTR) begin
              cnt        <= '0;
              phase      <= 2'd2;
              bus.sda_oe <= 1'b0;
            end else cnt <= cnt + 9'd1;
          end
          default: if (cnt == QTR) begin
            cnt           <= '0;
            state         <= IDLE;
            bus.cmd_ready <= 1'b1;
            bus.rsp_valid <= 1'b1;
            bus.rsp_nack  <= 1'b0;
            bus.busy      <= 1'b0;
          end else cnt <= cnt + 9'd1;
        endcase
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: doc/i2c_controller.md
# i2c_controller

Byte-level I2C controller (bus initiator) that drives the open-drain SCL/SDA pair through a command/response handshake. It generates START, repeated START, STOP, 8-bit WRITE and 8-bit READ sequences, and honours target clock stretching. It is the far end of the bus from `i2c_peripheral`: it feeds the I2C side of the bridge in bench and loopback builds, and it is the I2C side of the planned SPI-to-I2C direction.

## Interface
- `CLK_DIV`, default 5: quarter SCL bit period in `clk` cycles. Legal range is 2..255.
- `clk`  in  1  system clock; all logic is on its rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `cmd_valid`  in  1  a command is presented.
- `cmd_ready`  out  1  the block is idle and will accept a command.
- `cmd_op`  in  2  command code: 0 START (repeated START if `busy`), 1 WRITE, 2 READ, 3 STOP.
- `cmd_data`  in  8  byte to send for WRITE, MSB first.
- `cmd_nack_last`  in  1  READ only: 1 sends NACK in the ACK slot, 0 sends ACK.
- `rsp_valid`  out  1  one-cycle pulse when a command completes.
- `rsp_data`  out  8  last byte read; held until the next READ completes.
- `rsp_nack`  out  1  WRITE: 1 if the target NACKed. READ: the ACK value the controller drove. Held until the next completion.
- `busy`  out  1  the controller owns the bus (a START has been issued and no STOP yet).
- `scl_in`, `sda_in`  in  1  raw bus levels. Each passes through an internal 2-flop synchronizer.
- `scl_oe`, `sda_oe`  out  1  1 pulls the line low; 0 releases it.

## Operation
- **States:** IDLE, START, WRBIT, RDBIT, ACK, STOP.
- **Accept rule:** a command is accepted on a cycle with `cmd_valid && cmd_ready`. `cmd_op`, `cmd_data` and `cmd_nack_last` are latched on that cycle.
- **Bit slot phases:** each bit slot has four phases.
  - P0: SCL low, CLK_DIV cycles. SDA is updated on the first cycle of P0.
  - P1: SCL low, CLK_DIV cycles.
  - P2: SCL released. The phase counter advances only while synchronized SCL is high, so clock stretching extends P2 indefinitely.
  - P3: SCL high, CLK_DIV cycles. SDA is sampled on the first cycle of P3.
- **WRITE:**
  - 8 WRBIT slots, MSB first, with `sda_oe = ~bit`.
  - Then an ACK slot with SDA released; `rsp_nack` = sampled SDA.
  - SCL is left driven low at the end.
- **READ:**
  - 8 RDBIT slots with SDA released, shifted in MSB first.
  - Then an ACK slot with `sda_oe = ~cmd_nack_last`; `rsp_nack = cmd_nack_last`.
  - `rsp_data` updates on the completion cycle.
- **START from idle:**
  - Release SDA and SCL, then wait CLK_DIV counted cycles of synchronized SCL high.
  - Pull SDA low for 2·CLK_DIV cycles, then SCL low for CLK_DIV cycles.
  - Set `busy` = 1.
- **Repeated START (`busy` = 1):**
  - First release SDA for CLK_DIV cycles with SCL low.
  - Then run the same sequence as START from idle.
- **STOP:**
  - SCL low with SDA low for CLK_DIV cycles.
  - Release SCL, then wait CLK_DIV counted cycles of SCL high.
  - Release SDA and hold for CLK_DIV cycles.
  - Clear `busy`; both oe outputs end at 0.
- **Commands while `busy` = 0:**
  - WRITE or READ completes on the cycle after acceptance with `rsp_nack` = 1 and no bus activity.
  - STOP completes on the cycle after acceptance with `rsp_nack` = 0 and no bus activity.
- Multi-master arbitration is not supported; SDA is never compared against its driven value.

## Timing
- **Reset values:** `scl_oe` = 0, `sda_oe` = 0, `cmd_ready` = 1, `rsp_valid` = 0, `rsp_data` = 0x00, `rsp_nack` = 0, `busy` = 0. Synchronizers reset to 1.
- **Reset mid-operation:** both lines are released asynchronously; no `rsp_valid` is issued afterwards.
- **Handshake timing:**
  - `cmd_ready` falls on the cycle after acceptance.
  - `cmd_ready` rises on the same cycle as `rsp_valid`, so a command presented on that cycle is accepted with zero bubble.
- **Unstretched bit slot:** 4·CLK_DIV + 2 cycles, where the +2 is synchronizer delay in P2.
- **Unstretched command latency,** from acceptance to `rsp_valid`:
  - WRITE/READ: 9·(4·CLK_DIV + 2) + 1 cycles.
  - START from idle: 4·CLK_DIV + 3 cycles.
  - STOP: 3·CLK_DIV + 3 cycles.
- **Clock stretching:** adds exactly the number of cycles synchronized SCL stays low after release.
- **SDA stability:** SDA never changes while `scl_oe` = 0 and synchronized SCL is high, except for START/STOP edges.

## Test plan
- **Reset:** assert `rst_n` low mid-WRITE → `scl_oe`/`sda_oe` go to 0 in the same cycle; after release all outputs are at reset values and `cmd_ready` = 1.
- **Addressed write:** START, then WRITE 0x50 to an `i2c_peripheral` model at address 0x28 → SDA bits 0101_0000, target ACKs, `rsp_nack` = 0, `busy` = 1; latency is 9·22+1 = 199 cycles with CLK_DIV = 5.
- **Unanswered address:** START, then WRITE 0x52 with no target present → `rsp_nack` = 1; STOP then returns both lines released and `busy` = 0.
- **Read with NACK:** target drives 0xA5; READ with `cmd_nack_last` = 1 → `rsp_data` = 0xA5, `rsp_nack` = 1, SDA released in the ACK slot. Repeat with `cmd_nack_last` = 0 → SDA driven low in the ACK slot.
- **Clock stretch:** target holds SCL low for 50 cycles in bit 3 of a WRITE 0xC3 → the byte is still correct and latency increases by exactly 50.
- **Idle and back-to-back:** READ while idle → `rsp_valid` on the next cycle with `rsp_nack` = 1 and no line activity. A repeated START issued back-to-back in the `rsp_valid` cycle → accepted with zero bubble; SDA rises while SCL is low, then falls while SCL is high.
